alu_issue_unit: RTL

- Initiator side of the ALU operation interface.
- Accepts decoded-instruction requests through a valid/ready handshake and translates opcode/funct into the 3-bit ALU Control code.
- Registers and drives the operands to the combinational ALU, captures the returned Result, and delivers it on a valid/ready response port.
- Sits between the register-read stage and the ALU in the execute path.

---
 rtl/alu_issue_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - ALU issue unit: decodes requests, drives the ALU, returns the result.
// Optional macro ALU_MUL_EN enables the Opcode 0x1C / Funct 0x02 multiply decode.
module alu_issue_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            Funct,
  input  logic [15:0]           Imm,
  input  logic [DATA_WIDTH-1:0] RsData,
  input  logic [DATA_WIDTH-1:0] RtData,
  output logic [2:0]            Control,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] Result,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspResult,
  output logic                  RspIllegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [2:0] CTRL_ADD  = 3'b000;
  localparam logic [2:0] CTRL_SUB  = 3'b001;
  localparam logic [2:0] CTRL_AND  = 3'b011;
  localparam logic [2:0] CTRL_OR   = 3'b100;
  localparam logic [2:0] CTRL_XOR  = 3'b101;
  localparam logic [2:0] CTRL_IDLE = 3'b111;
`ifdef ALU_MUL_EN
  localparam logic [2:0] CTRL_MUL  = 3'b010;
`endif

  state_t                state, state_nxt;
  logic [2:0]            ctrl_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, rsp_result_q;
  logic                  rsp_illegal_q;

  logic                  dec_legal;
  logic [2:0]            dec_ctrl;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [DATA_WIDTH-1:0] imm_sext, imm_zext;

  assign imm_sext = {{(DATA_WIDTH-16){Imm[15]}}, Imm};
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, Imm};

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = CTRL_IDLE;
    dec_b     = RtData;
    case (Opcode)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21: begin dec_legal = 1'b1; dec_ctrl = CTRL_ADD; end
          6'h22, 6'h23: begin dec_legal = 1'b1; dec_ctrl = CTRL_SUB; end
          6'h24:        begin dec_legal = 1'b1; dec_ctrl = CTRL_AND; end
          6'h25:        begin dec_legal = 1'b1; dec_ctrl = CTRL_OR;  end
          6'h26:        begin dec_legal = 1'b1; dec_ctrl = CTRL_XOR; end
          default: ;
        endcase
      end
`ifdef ALU_MUL_EN
      6'h1C: begin
        if (Funct == 6'h02) begin
          dec_legal = 1'b1;
          dec_ctrl  = CTRL_MUL;
        end
      end
`endif
      6'h08, 6'h09: begin dec_legal = 1'b1; dec_ctrl = CTRL_ADD; dec_b = imm_sext; end
      6'h0C:        begin dec_legal = 1'b1; dec_ctrl = CTRL_AND; dec_b = imm_zext; end
      6'h0D:        begin dec_legal = 1'b1; dec_ctrl = CTRL_OR;  dec_b = imm_zext; end
      6'h0E:        begin dec_legal = 1'b1; dec_ctrl = CTRL_XOR; dec_b = imm_zext; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ReqReady  = 1'b0;
    RspValid  = 1'b0;
    Control   = CTRL_IDLE;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_nxt = dec_legal ? ISSUE : RESP;
      end
      ISSUE: begin
        Control   = ctrl_q;
        state_nxt = RESP;
      end
      RESP: begin
        RspValid = 1'b1;
        if (RspReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Illegal requests skip ISSUE, so the response registers are set at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q        <= CTRL_ADD;
      a_q           <= '0;
      b_q           <= '0;
      rsp_result_q  <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            if (dec_legal) begin
              ctrl_q        <= dec_ctrl;
              a_q           <= RsData;
              b_q           <= dec_b;
              rsp_illegal_q <= 1'b0;
            end else begin
              rsp_illegal_q <= 1'b1;
              rsp_result_q  <= '0;
            end
          end
        end
        ISSUE:   rsp_result_q <= Result;
        default: ;
      endcase
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign RspResult  = rsp_result_q;
  assign RspIllegal = rsp_illegal_q;

endmodule
